// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream (s[n+8] = s[n]^s[n+2]^s[n+3]^s[n+4]).
// Latency: locked/err_pulse/err_cnt update on the clock edge that accepts the deciding bit.
// Backpressure: none; bits are accepted whenever bit_valid is high.
module lfsr_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        err_clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [7:0]  w, w_d;
    logic [2:0]  fill_cnt, fill_d;
    logic [7:0]  good_cnt, good_d;
    logic [3:0]  run_cnt, run_d;
    logic        locked_d;
    logic        pulse_d;
    logic [15:0] err_d;
    logic        pred;
    logic        match;
    logic        cnt_mis;

    // Taps 4,3,2,0 of the window predict the next stream bit.
    assign pred  = ^(w & 8'h1D);
    assign match = (bit_in == pred);

    always_comb begin
        state_d  = state;
        w_d      = w;
        fill_d   = fill_cnt;
        good_d   = good_cnt;
        run_d    = run_cnt;
        locked_d = locked;
        pulse_d  = 1'b0;
        cnt_mis  = 1'b0;
        if (bit_valid) begin
            case (state)
                LOAD: begin
                    w_d    = {bit_in, w[7:1]};
                    fill_d = fill_cnt + 3'd1;
                    if (fill_cnt == 3'd7) begin
                        state_d = VERIFY;
                        good_d  = 8'd0;
                    end
                end
                VERIFY: begin
                    w_d = {bit_in, w[7:1]};
                    if (!match) begin
                        good_d = 8'd0;
                    end else if (w != 8'h00) begin
                        // An all-zero window predicts zeros forever; never credit it.
                        if (good_cnt == 8'(LOCK_CNT - 1)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            good_d   = 8'd0;
                            run_d    = 4'd0;
                        end else begin
                            good_d = good_cnt + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    // Flywheel: the window follows the prediction, so a bad bit costs one mismatch.
                    w_d = {pred, w[7:1]};
                    if (match) begin
                        if (good_cnt == 8'd7) begin
                            good_d = 8'd0;
                            run_d  = 4'd0;
                        end else begin
                            good_d = good_cnt + 8'd1;
                        end
                    end else begin
                        pulse_d = 1'b1;
                        cnt_mis = 1'b1;
                        good_d  = 8'd0;
                        if (run_cnt == 4'(LOSS_THR - 1)) begin
                            state_d  = LOAD;
                            w_d      = 8'h00;
                            fill_d   = 3'd0;
                            run_d    = 4'd0;
                            locked_d = 1'b0;
                        end else begin
                            run_d = run_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d  = LOAD;
                    w_d      = 8'h00;
                    fill_d   = 3'd0;
                    good_d   = 8'd0;
                    run_d    = 4'd0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // A clear coinciding with a counted mismatch keeps that mismatch.
    always_comb begin
        err_d = err_cnt;
        if (err_clr) begin
            err_d = cnt_mis ? 16'd1 : 16'd0;
        end else if (cnt_mis && (err_cnt != 16'hFFFF)) begin
            err_d = err_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            w         <= 8'h00;
            fill_cnt  <= 3'd0;
            good_cnt  <= 8'd0;
            run_cnt   <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            state     <= state_d;
            w         <= w_d;
            fill_cnt  <= fill_d;
            good_cnt  <= good_d;
            run_cnt   <= run_d;
            locked    <= locked_d;
            err_pulse <= pulse_d;
            err_cnt   <= err_d;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: stream built from the recurrence identity, expectations from the lock/loss rules.
module tb_lfsr_checker;

    localparam int LOCK = 16;
    localparam int LOSS = 4;
    localparam int NS   = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int sp = 0;
    bit s [NS];

    lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_THR(LOSS)) dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input bit v, input bit b, input bit clr);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        err_clr   = clr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic send(input bit inv, input bit clr);
        step(1'b1, s[sp] ^ inv, clr);
        sp++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bit_valid = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_up(input int start);
        do_reset();
        sp = start;
        repeat (LOCK + 8) send(1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_up start=%0d: locked=%b want 1", start, locked);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, err_pulse, err_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL reset_values: locked=%b pulse=%b cnt=%0d want 0/0/0", locked, err_pulse, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if ({locked, err_pulse, err_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL reset_idle: locked=%b pulse=%b cnt=%0d want 0/0/0", locked, err_pulse, err_cnt);
        end
    endtask

    task automatic test_lock();
        do_reset();
        sp = 0;
        for (int n = 1; n <= 40; n++) begin
            send(1'b0, 1'b0);
            checks++;
            if (locked !== (n >= LOCK + 8) || err_cnt !== 16'd0 || err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL lock_seq bit=%0d: locked=%b cnt=%0d pulse=%b want %b/0/0",
                         n, locked, err_cnt, err_pulse, n >= LOCK + 8);
            end
        end
    endtask

    task automatic test_single_error();
        lock_up(5);
        send(1'b1, 1'b0);
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL single_err: pulse=%b cnt=%0d locked=%b want 1/1/1", err_pulse, err_cnt, locked);
        end
        for (int n = 0; n < 20; n++) begin
            send(1'b0, 1'b0);
            checks++;
            if (err_pulse !== 1'b0 || err_cnt !== 16'd1 || locked !== 1'b1) begin
                errors++;
                $display("FAIL single_err_after bit=%0d: pulse=%b cnt=%0d locked=%b want 0/1/1",
                         n, err_pulse, err_cnt, locked);
            end
        end
    endtask

    task automatic test_loss_relock();
        lock_up(40);
        for (int k = 1; k <= LOSS; k++) begin
            send(1'b1, 1'b0);
            checks++;
            if (err_cnt !== 16'(k) || err_pulse !== 1'b1 || locked !== (k < LOSS)) begin
                errors++;
                $display("FAIL loss k=%0d: cnt=%0d pulse=%b locked=%b want %0d/1/%b",
                         k, err_cnt, err_pulse, locked, k, k < LOSS);
            end
        end
        for (int n = 1; n <= LOCK + 8; n++) begin
            send(1'b0, 1'b0);
            checks++;
            if (locked !== (n == LOCK + 8) || err_cnt !== 16'(LOSS)) begin
                errors++;
                $display("FAIL relock bit=%0d: locked=%b cnt=%0d want %b/%0d",
                         n, locked, err_cnt, n == LOCK + 8, LOSS);
            end
        end
    endtask

    task automatic test_zeros();
        bit seen = 0;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            step(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0 || err_cnt !== 16'd0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL zeros: some cycle had locked or err_cnt set, final locked=%b cnt=%0d want 0/0",
                     locked, err_cnt);
        end
    endtask

    task automatic test_err_clr();
        lock_up(100);
        for (int k = 0; k < 2; k++) begin
            send(1'b1, 1'b0);
            repeat (9) send(1'b0, 1'b0);
        end
        checks++;
        if (err_cnt !== 16'd2 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre: cnt=%0d locked=%b want 2/1", err_cnt, locked);
        end
        send(1'b1, 1'b1);
        checks++;
        if (err_cnt !== 16'd1 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_err: cnt=%0d pulse=%b want 1/1", err_cnt, err_pulse);
        end
        send(1'b0, 1'b1);
        checks++;
        if (err_cnt !== 16'd0 || err_pulse !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL clr_alone: cnt=%0d pulse=%b locked=%b want 0/0/1", err_cnt, err_pulse, locked);
        end
    endtask

    task automatic test_sparse_and_async_reset();
        do_reset();
        sp = 0;
        for (int n = 1; n <= LOCK + 8; n++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (locked !== 1'b0) begin
                errors++;
                $display("FAIL sparse_idle before bit %0d: locked=%b want 0", n, locked);
            end
            send(1'b0, 1'b0);
        end
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL sparse_lock: locked=%b want 1", locked);
        end
        step(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (err_cnt !== 16'd1 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL sparse_err: cnt=%0d pulse=%b want 1/0", err_cnt, err_pulse);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: locked=%b cnt=%0d want 0/0", locked, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= LOCK + 8; n++) begin
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            send(1'b0, 1'b0);
            checks++;
            if (locked !== (n == LOCK + 8)) begin
                errors++;
                $display("FAIL restart bit=%0d: locked=%b want %b", n, locked, n == LOCK + 8);
            end
        end
    endtask

    task automatic test_random_errors();
        int  exp_err, misses, clean_run, gap;
        bit  lost;
        lock_up($urandom_range(0, 300));
        exp_err = 0; misses = 0; clean_run = 0; lost = 0;
        for (int k = 0; k < 12 && !lost; k++) begin
            gap = $urandom_range(2, 12);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                send(1'b0, 1'b0);
                clean_run++;
                if (clean_run >= 8) misses = 0;
                checks++;
                if (err_pulse !== 1'b0 || locked !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_clean k=%0d g=%0d: pulse=%b locked=%b want 0/1", k, g, err_pulse, locked);
                end
            end
            send(1'b1, 1'b0);
            exp_err++;
            misses++;
            clean_run = 0;
            if (misses == LOSS) lost = 1;
            checks++;
            if (err_pulse !== 1'b1 || locked !== !lost) begin
                errors++;
                $display("FAIL rand_err k=%0d: pulse=%b locked=%b want 1/%b", k, err_pulse, locked, !lost);
            end
        end
        checks++;
        if (err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL rand_cnt: err_cnt=%0d want %0d", err_cnt, exp_err);
        end
        if (lost) begin
            repeat (LOCK + 8) send(1'b0, 1'b0);
            checks++;
            if (locked !== 1'b1 || err_cnt !== 16'(exp_err)) begin
                errors++;
                $display("FAIL rand_relock: locked=%b cnt=%0d want 1/%0d", locked, err_cnt, exp_err);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++)
            s[i] = (i < 8) ? (i == 0) : (s[i-8] ^ s[i-6] ^ s[i-5] ^ s[i-4]);
        test_reset();
        test_lock();
        test_single_error();
        test_loss_relock();
        test_zeros();
        test_err_clr();
        test_sparse_and_async_reset();
        for (int r = 0; r < 4; r++) test_random_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
